// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter and ALE/En/Rw sequencer for the shared 8-bit AD memory bus.
// Every output is registered from the current phase state, so bus phases trail the state register by one cycle.
module mem_bus_arbiter #(
    parameter int DATA_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic [1:0] grant,
    output logic       busy,
    output logic       mem_ale,
    output logic       mem_en,
    output logic       mem_rw,
    output logic [7:0] mem_ad_out,
    output logic       mem_ad_oe,
    input  logic [7:0] mem_ad_in
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    localparam logic [3:0] DC_INIT = 4'(DATA_CYCLES);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       owner, owner_nxt;   // 0 = port 0, 1 = port 1
    logic       last, last_nxt;     // port served most recently
    logic       we_l, we_l_nxt;
    logic [7:0] addr_l, addr_l_nxt;
    logic [7:0] wdata_l, wdata_l_nxt;
    logic       load;
    logic       pick;
    logic       idle_req0, idle_req1;

    // While an ack is on the wire the requester has not yet had a chance to drop req.
    assign idle_req0 = req0 & ~ack0;
    assign idle_req1 = req1 & ~ack1;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        last_nxt    = last;
        load        = 1'b0;
        pick        = owner;
        owner_nxt   = owner;
        we_l_nxt    = we_l;
        addr_l_nxt  = addr_l;
        wdata_l_nxt = wdata_l;

        case (state)
            IDLE: begin
                if (idle_req0 || idle_req1) begin
                    load      = 1'b1;
                    pick      = (idle_req0 && idle_req1) ? ~last : idle_req1;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                cnt_nxt   = DC_INIT;
                state_nxt = DATA;
            end
            DATA: begin
                if (cnt == 4'd1) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                last_nxt = owner;
                if (owner ? req0 : req1) begin
                    load      = 1'b1;
                    pick      = ~owner;
                    state_nxt = ADDR;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (load) begin
            owner_nxt   = pick;
            we_l_nxt    = pick ? we1 : we0;
            addr_l_nxt  = pick ? addr1 : addr0;
            wdata_l_nxt = pick ? wdata1 : wdata0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            owner   <= 1'b0;
            last    <= 1'b1;
            we_l    <= 1'b0;
            addr_l  <= 8'h00;
            wdata_l <= 8'h00;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            owner   <= owner_nxt;
            last    <= last_nxt;
            we_l    <= we_l_nxt;
            addr_l  <= addr_l_nxt;
            wdata_l <= wdata_l_nxt;
        end
    end

    // The last En cycle on the bus is the DONE state's cycle, so read data is sampled as DONE retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= 8'h00;
            rdata1     <= 8'h00;
            grant      <= 2'b00;
            busy       <= 1'b0;
            mem_ale    <= 1'b0;
            mem_en     <= 1'b0;
            mem_rw     <= 1'b1;
            mem_ad_out <= 8'h00;
            mem_ad_oe  <= 1'b0;
        end else begin
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            grant      <= 2'b00;
            busy       <= (state != IDLE);
            mem_ale    <= 1'b0;
            mem_en     <= 1'b0;
            mem_rw     <= 1'b1;
            mem_ad_out <= 8'h00;
            mem_ad_oe  <= 1'b0;

            case (state)
                ADDR: begin
                    grant      <= owner ? 2'b10 : 2'b01;
                    mem_ale    <= 1'b1;
                    mem_ad_oe  <= 1'b1;
                    mem_ad_out <= addr_l;
                    mem_rw     <= ~we_l;
                end
                DATA: begin
                    grant      <= owner ? 2'b10 : 2'b01;
                    mem_en     <= 1'b1;
                    mem_rw     <= ~we_l;
                    mem_ad_oe  <= we_l;
                    mem_ad_out <= we_l ? wdata_l : 8'h00;
                end
                DONE: begin
                    grant <= owner ? 2'b10 : 2'b01;
                    if (owner) begin
                        ack1 <= 1'b1;
                        if (!we_l) rdata1 <= mem_ad_in;
                    end else begin
                        ack0 <= 1'b1;
                        if (!we_l) rdata0 <= mem_ad_in;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter and bus sequencer for the shared 8-bit multiplexed address/data memory bus. It sits between the CPU controller (port 0) and the program loader/debug port (port 1). It accepts word-level read/write requests from each port, grants the bus round-robin, and generates the ALE/En/Rw phase sequence toward memory. Completion is signalled to the requester with a one-cycle ack, plus read data.

## Interface
- DATA_CYCLES, 1, number of En-asserted cycles per access (legal 1..15); read data sampled in the last one
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req0, req1  in  1  access request from port 0 (CPU) / port 1 (loader)
- we0, we1  in  1  1 = write, 0 = read; qualified by req
- addr0, addr1  in  8  access address
- wdata0, wdata1  in  8  write data
- ack0, ack1  out  1  one-cycle completion pulse
- rdata0, rdata1  out  8  read data, valid with ack, held until that port's next read completes
- grant  out  2  one-hot owner of the bus; 00 when idle
- busy  out  1  1 in any state other than IDLE
- mem_ale  out  1  address latch enable
- mem_en  out  1  memory enable
- mem_rw  out  1  1 = read, 0 = write
- mem_ad_out  out  8  value driven on the AD bus
- mem_ad_oe  out  1  AD bus output enable
- mem_ad_in  in  8  AD bus input from memory

## Operation
- States: IDLE, ADDR, DATA, DONE. All outputs are registered.
- IDLE: grant=00, mem_rw=1, all other bus outputs 0. If any req is high, pick a winner, latch its addr/we/wdata, set grant, go to ADDR.
- Arbitration is round-robin with a last-served pointer. On a tie, the port not served last wins. A lone request always wins.
- ADDR (1 cycle): mem_ale=1, mem_ad_oe=1, mem_ad_out=latched addr, mem_rw=~we.
- DATA (DATA_CYCLES cycles, 4-bit down-counter): mem_en=1, mem_rw=~we, mem_ale=0.
  - Write: mem_ad_oe=1, mem_ad_out=wdata.
  - Read: mem_ad_oe=0; mem_ad_in is captured into the granted port's rdata at the end of the last DATA cycle.
- DONE (1 cycle): mem_en=0, mem_ad_oe=0, mem_rw=1, ack of the served port=1. Update the last-served pointer.
  - The served port's req is masked in this cycle.
  - If the other port's req is high, latch it and go directly to ADDR (back-to-back). Otherwise go to IDLE.
- Requester rules:
  - Hold req, we, addr and wdata stable from assertion until ack.
  - A req still high in the cycle after ack is a new request.
- Request fields are latched at grant, so later changes do not affect the access in flight.
- The rdata of the non-served port is never modified.

## Timing
- Reset values: state IDLE, grant=00, busy=0, ack0=ack1=0, rdata0=rdata1=00, mem_ale=mem_en=mem_ad_oe=0, mem_rw=1, mem_ad_out=00, last-served pointer = port 1 (port 0 wins the first tie).
- Access length is 2+DATA_CYCLES cycles (ADDR + DATA + DONE).
  - Latency from req sampled high in IDLE to ack = 3+DATA_CYCLES cycles.
  - Back-to-back throughput: one access per 2+DATA_CYCLES cycles.
- mem_ale and mem_en are never high in the same cycle.
- mem_ad_oe is never high while mem_rw=1 during DATA.
- rst in any state (including mid-DATA) returns to reset values on the next edge. The in-flight access is abandoned with no ack, and rdata is unchanged from its reset value.
- A req that drops before its grant is ignored. A req that drops after grant still completes and acks.

## Test plan
- Port-0 read at addr 0x2A with memory returning 0x5C, DATA_CYCLES=1:
  - ADDR cycle: ale=1, ad_out=0x2A, rw=1.
  - Next cycle: en=1, oe=0.
  - Next cycle: ack0=1, rdata0=0x5C, 4 cycles after req. rdata1 stays 00.
- Port-1 write 0x77 to 0x10:
  - ADDR: ad_out=0x10, rw=0, oe=1.
  - DATA: en=1, rw=0, ad_out=0x77.
  - DONE: ack1=1, grant returns to 00 the cycle after.
- req0 and req1 rise together after reset:
  - Port 0 is served first; ack0 in DONE is immediately followed by ADDR for port 1, with no IDLE in between.
  - ack1 follows 3 cycles after ack0.
- Both req held high continuously for 6 accesses:
  - grant alternates 01,10,01,10,01,10.
  - Exactly one ack per access; no port is served twice in a row.
- DATA_CYCLES=3, port-0 read:
  - en high for exactly 3 cycles.
  - Data is captured in the third cycle only: memory changes 0x11 to 0x22 before the third cycle, and rdata0 must be 0x22.
  - ack0 occurs 6 cycles after req.
- rst asserted in the second DATA cycle of a port-1 write (DATA_CYCLES=3):
  - Next cycle shows all reset values.
  - ack1 never pulses.
  - With req0 and req1 then high together, port 0 is granted first.
